// File: rtl/mem_store_responder_if.sv
// Bus between the M stage / MMIO peripheral and the data-side responder.
// Handshake: the responder holds io_valid, io_addr and io_data steady until io_valid & io_ready.
interface mem_store_responder_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          memwriteM;
    logic [31:0]   aluoutM;
    logic [31:0]   writedataM;
    logic [31:0]   readdataM;
    logic          stallM;
    logic          io_valid;
    logic [7:0]    io_addr;
    logic [31:0]   io_data;
    logic          io_ready;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  memwriteM, aluoutM, writedataM, io_ready,
        output readdataM, stallM, io_valid, io_addr, io_data, fifo_count
    );

    modport master (
        output memwriteM, aluoutM, writedataM, io_ready,
        input  readdataM, stallM, io_valid, io_addr, io_data, fifo_count
    );
endinterface

// File: rtl/mem_store_responder.sv
// Memory-stage data responder: word RAM plus an MMIO region whose stores are posted
// through a small FIFO to a valid/ready peripheral port.
module mem_store_responder #(
    parameter int          RAM_WORDS    = 64,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF0000,
    parameter bit          DROP_ON_FULL = 1'b0
) (
    input logic                  clk,
    input logic                  reset,
    mem_store_responder_if.slave bus
);
    localparam int            AW         = $clog2(RAM_WORDS);
    localparam int            PW         = $clog2(FIFO_DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic          isMmio;
    logic [AW-1:0] ramIdx;
    logic [15:0]   offset;
    logic          enqReq;
    logic          isStatusRd;
    logic          isDropRd;

    assign isMmio     = (bus.aluoutM[31:16] == MMIO_BASE[31:16]);
    assign ramIdx     = bus.aluoutM[AW+1:2];
    assign offset     = bus.aluoutM[15:0];
    // Only the first 16 word offsets of the region are posted; the rest are read-only registers.
    assign enqReq     = bus.memwriteM & isMmio & (offset[15:6] == '0);
    assign isStatusRd = isMmio & (offset[15:2] == 14'h0010);
    assign isDropRd   = isMmio & (offset[15:2] == 14'h0011);

    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (bus.memwriteM && !isMmio) begin
            ram[ramIdx] <= bus.writedataM;
        end
    end

    logic [7:0]    addrMem [FIFO_DEPTH];
    logic [31:0]   dataMem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] fifoCount;
    logic [15:0]   dropCnt;
    logic          empty;
    logic          full;
    logic          deq;
    logic          accept;
    logic          reject;
    logic          stall;

    assign empty  = (fifoCount == '0);
    assign full   = (fifoCount == FULL_COUNT);
    assign deq    = !empty & bus.io_ready;
    // A dequeue in the same cycle frees the head slot, so a full FIFO can still accept.
    assign accept = enqReq & (!full | deq);
    assign reject = enqReq & !accept;

    always_ff @(posedge clk) begin
        if (accept) begin
            addrMem[wrPtr] <= offset[7:0];
            dataMem[wrPtr] <= bus.writedataM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (accept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (deq) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({accept, deq})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    generate
        if (DROP_ON_FULL) begin : g_drop
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dropCnt <= '0;
                end else if (reject && (dropCnt != 16'hFFFF)) begin
                    dropCnt <= dropCnt + 1'b1;
                end
            end
            assign stall = 1'b0;
        end else begin : g_stall
            // The core holds the store in M and re-presents it until it is accepted.
            assign dropCnt = '0;
            assign stall   = reject;
        end
    endgenerate

    logic [31:0] statusWord;
    logic [31:0] readData;

    assign statusWord = 32'({fifoCount, full, empty});

    always_comb begin
        readData = ram[ramIdx];
        if (isMmio) begin
            readData = '0;
            if (isStatusRd) begin
                readData = statusWord;
            end else if (isDropRd) begin
                readData = {16'b0, dropCnt};
            end
        end
    end

    assign bus.readdataM  = readData;
    assign bus.stallM     = stall;
    assign bus.io_valid   = !empty;
    assign bus.io_addr    = addrMem[rdPtr];
    assign bus.io_data    = dataMem[rdPtr];
    assign bus.fifo_count = fifoCount;
endmodule

// File: tb/tb_mem_store_responder.sv
// Bench for mem_store_responder: a stall-mode and a drop-mode instance driven from directed
// vector tables, hand-written corner sequences and a randomized run against a queue model.
module tb_mem_store_responder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_store_responder_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
    mem_store_responder_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

    mem_store_responder #(
        .RAM_WORDS(64), .FIFO_DEPTH(DEPTH), .MMIO_BASE(32'hFFFF0000), .DROP_ON_FULL(1'b0)
    ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    mem_store_responder #(
        .RAM_WORDS(64), .FIFO_DEPTH(DEPTH), .MMIO_BASE(32'hFFFF0000), .DROP_ON_FULL(1'b1)
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        chkRd;
        logic [31:0] expRd;
        logic        expStall;
        int          expCnt;
        logic        expValid;
        logic [31:0] expHead;
    } vec_t;

    vec_t vecs[$];
    int   nAssert = 0;
    int   nFail   = 0;

    // Reference model state for the randomized run
    logic [39:0] exp_q[$];
    logic [39:0] exp_q1[$];
    int          drops1;
    logic [31:0] mram [64];
    bit          mknown [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        bus0.memwriteM  = we;
        bus0.aluoutM    = a;
        bus0.writedataM = d;
        bus0.io_ready   = rdy;
    endtask

    task automatic drive1(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        bus1.memwriteM  = we;
        bus1.aluoutM    = a;
        bus1.writedataM = d;
        bus1.io_ready   = rdy;
    endtask

    function automatic void addVec(input logic we, input logic [31:0] a, input logic [31:0] d,
                                   input logic rdy, input logic chkRd, input logic [31:0] rd,
                                   input logic st, input int cnt, input logic v, input logic [31:0] head);
        vec_t t;
        t = '{we, a, d, rdy, chkRd, rd, st, cnt, v, head};
        vecs.push_back(t);
    endfunction

    // Status word built from occupancy: empty at bit 0, full at bit 1, count from bit 2.
    function automatic logic [31:0] mmioRead(input int off, input int n, input int drops);
        if ((off >> 2) == 'h10) return 32'((n * 4) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
        if ((off >> 2) == 'h11) return 32'(drops);
        return 32'h0;
    endfunction

    task automatic doReset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int          pct;
        bit          hold;
        logic        we, rdy, mmio, enq, deq0, deq1, acc0, acc1, expStall0;
        logic [31:0] a, d;
        int          idx, off, n0, n1, k;

        // RAM: two stores then two loads
        addVec(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 32'h14, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
        addVec(0, 32'h10, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
        addVec(0, 32'h14, 0, 0, 1, 32'h12345678, 0, 0, 0, 0);
        // Same-cycle write returns the old word
        addVec(1, 32'h20, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 32'h20, 32'hA5A5A5A5, 0, 1, 32'h1, 0, 0, 0, 0);
        addVec(0, 32'h20, 0, 0, 1, 32'hA5A5A5A5, 0, 0, 0, 0);
        // MMIO fill, stall, stall release on ready, drain
        addVec(1, 32'hFFFF0004, 1, 0, 1, 0, 0, 0, 0, 0);
        addVec(1, 32'hFFFF0004, 2, 0, 1, 0, 0, 1, 1, 1);
        addVec(1, 32'hFFFF0004, 3, 0, 1, 0, 0, 2, 1, 1);
        addVec(1, 32'hFFFF0004, 4, 0, 1, 0, 0, 3, 1, 1);
        addVec(0, 32'hFFFF0040, 0, 0, 1, 32'h12, 0, 4, 1, 1);
        addVec(1, 32'hFFFF0004, 5, 0, 1, 0, 1, 4, 1, 1);
        addVec(1, 32'hFFFF0004, 5, 1, 1, 0, 0, 4, 1, 1);
        addVec(0, 32'hFFFF0040, 0, 1, 1, 32'h12, 0, 4, 1, 2);
        addVec(0, 32'hFFFF0040, 0, 1, 1, 32'h0C, 0, 3, 1, 3);
        addVec(0, 32'hFFFF0040, 0, 1, 1, 32'h08, 0, 2, 1, 4);
        addVec(0, 32'hFFFF0040, 0, 1, 1, 32'h04, 0, 1, 1, 5);
        addVec(0, 32'hFFFF0040, 0, 0, 1, 32'h01, 0, 0, 0, 0);

        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset fifo_count0", 32'(bus0.fifo_count), 0);
        chk("reset io_valid0", 32'(bus0.io_valid), 0);
        chk("reset stallM0", 32'(bus0.stallM), 0);
        chk("reset fifo_count1", 32'(bus1.fifo_count), 0);
        chk("reset io_valid1", 32'(bus1.io_valid), 0);
        reset = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive0(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
            @(negedge clk);
            if (vecs[i].chkRd) chk($sformatf("vec%0d readdataM", i), bus0.readdataM, vecs[i].expRd);
            chk($sformatf("vec%0d stallM", i), 32'(bus0.stallM), 32'(vecs[i].expStall));
            chk($sformatf("vec%0d fifo_count", i), 32'(bus0.fifo_count), 32'(vecs[i].expCnt));
            chk($sformatf("vec%0d io_valid", i), 32'(bus0.io_valid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                chk($sformatf("vec%0d io_data", i), bus0.io_data, vecs[i].expHead);
                chk($sformatf("vec%0d io_addr", i), 32'(bus0.io_addr), 32'h04);
            end
            tick();
        end

        // Wrap-around: one enqueue and one dequeue per cycle
        for (int i = 0; i <= 10; i++) begin
            drive0(i < 10, 32'hFFFF0008, 32'(100 + i), 1);
            @(negedge clk);
            chk($sformatf("wrap%0d fifo_count", i), 32'(bus0.fifo_count), (i == 0) ? 0 : 1);
            if (i > 0) begin
                chk($sformatf("wrap%0d io_data", i), bus0.io_data, 32'(100 + i - 1));
                chk($sformatf("wrap%0d io_addr", i), 32'(bus0.io_addr), 32'h08);
            end
            tick();
        end
        drive0(0, 0, 0, 0);
        @(negedge clk);
        chk("wrap end io_valid", 32'(bus0.io_valid), 0);
        tick();

        // Drop mode: fill, three rejected stores, drop count, original entries kept
        for (int i = 0; i < 7; i++) begin
            drive1(1, 32'hFFFF0000, 32'(i + 1), 0);
            @(negedge clk);
            chk($sformatf("drop%0d stallM", i), 32'(bus1.stallM), 0);
            chk($sformatf("drop%0d fifo_count", i), 32'(bus1.fifo_count), (i < 4) ? i : 4);
            tick();
        end
        drive1(0, 32'hFFFF0044, 0, 0);
        @(negedge clk);
        chk("drop count read", bus1.readdataM, 3);
        chk("drop keep count", 32'(bus1.fifo_count), 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive1(0, 32'hFFFF0044, 0, 1);
            @(negedge clk);
            chk($sformatf("drop drain%0d io_valid", i), 32'(bus1.io_valid), 1);
            chk($sformatf("drop drain%0d io_data", i), bus1.io_data, 32'(i + 1));
            tick();
        end
        drive1(0, 0, 0, 0);
        @(negedge clk);
        chk("drop drained io_valid", 32'(bus1.io_valid), 0);
        tick();

        // Asynchronous reset while the head is being offered
        for (int i = 0; i < 3; i++) begin
            drive0(1, 32'hFFFF0010, 32'h30 + 32'(i), 0);
            tick();
        end
        drive0(0, 0, 0, 0);
        @(negedge clk);
        chk("pre-reset io_valid", 32'(bus0.io_valid), 1);
        chk("pre-reset fifo_count", 32'(bus0.fifo_count), 3);
        #2 reset = 1'b0;
        #1;
        chk("async reset io_valid", 32'(bus0.io_valid), 0);
        chk("async reset fifo_count", 32'(bus0.fifo_count), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        drive0(1, 32'hFFFF000C, 32'h77, 0);
        drive1(0, 32'hFFFF0044, 0, 0);
        @(negedge clk);
        chk("post-reset first fifo_count", 32'(bus0.fifo_count), 0);
        chk("post-reset drop count", bus1.readdataM, 0);
        tick();
        drive0(0, 0, 0, 0);
        @(negedge clk);
        chk("post-reset enq count", 32'(bus0.fifo_count), 1);
        chk("post-reset enq io_data", bus0.io_data, 32'h77);
        chk("post-reset enq io_addr", 32'(bus0.io_addr), 32'h0C);
        tick();

        // Randomized run: identical stimulus to both instances, each against a queue model
        doReset();
        exp_q.delete();
        exp_q1.delete();
        drops1 = 0;
        foreach (mknown[i]) mknown[i] = 1'b0;
        hold = 1'b0;
        pct = 50;
        we = 1'b0;
        a = '0;
        d = '0;
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) pct = $urandom_range(10, 90);
            if (!hold) begin
                k = $urandom_range(0, 9);
                d = $urandom;
                if (k < 4) begin
                    a = 32'(($urandom_range(0, 255) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
                    we = 1'($urandom_range(0, 1));
                end else if (k < 7) begin
                    a = 32'hFFFF0000 | 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
                    we = 1'b1;
                end else if (k == 7) begin
                    a = ($urandom_range(0, 1) == 0) ? 32'hFFFF0040 : 32'hFFFF0044;
                    we = 1'($urandom_range(0, 1));
                end else if (k == 8) begin
                    a = 32'hFFFF0000 | (32'($urandom_range(16'h48, 16'hFFFF)) & 32'hFFFC);
                    we = 1'($urandom_range(0, 1));
                end else begin
                    a = 32'($urandom_range(0, 255));
                    we = 1'b0;
                end
            end
            rdy = ($urandom_range(0, 99) < pct);
            drive0(we, a, d, rdy);
            drive1(we, a, d, rdy);
            @(negedge clk);

            mmio = (a[31:16] == 16'hFFFF);
            idx  = int'(a[7:2]);
            off  = int'(a[15:0]);
            enq  = we && mmio && (off < 'h40);
            n0   = exp_q.size();
            n1   = exp_q1.size();
            deq0 = (n0 > 0) && rdy;
            deq1 = (n1 > 0) && rdy;
            acc0 = enq && ((n0 < DEPTH) || deq0);
            acc1 = enq && ((n1 < DEPTH) || deq1);
            expStall0 = enq && !acc0;

            if (mmio) begin
                chk($sformatf("rnd%0d readdataM0", c), bus0.readdataM, mmioRead(off, n0, 0));
                chk($sformatf("rnd%0d readdataM1", c), bus1.readdataM, mmioRead(off, n1, drops1));
            end else if (mknown[idx]) begin
                chk($sformatf("rnd%0d ram0", c), bus0.readdataM, mram[idx]);
                chk($sformatf("rnd%0d ram1", c), bus1.readdataM, mram[idx]);
            end
            chk($sformatf("rnd%0d stallM0", c), 32'(bus0.stallM), 32'(expStall0));
            chk($sformatf("rnd%0d stallM1", c), 32'(bus1.stallM), 0);
            chk($sformatf("rnd%0d fifo_count0", c), 32'(bus0.fifo_count), 32'(n0));
            chk($sformatf("rnd%0d fifo_count1", c), 32'(bus1.fifo_count), 32'(n1));
            chk($sformatf("rnd%0d io_valid0", c), 32'(bus0.io_valid), 32'(n0 > 0));
            chk($sformatf("rnd%0d io_valid1", c), 32'(bus1.io_valid), 32'(n1 > 0));
            if (n0 > 0) chk($sformatf("rnd%0d head0", c), {bus0.io_addr, bus0.io_data}, exp_q[0][31:0] | 32'h0) ;
            if (n0 > 0) chk($sformatf("rnd%0d head0 addr", c), 32'(bus0.io_addr), 32'(exp_q[0][39:32]));
            if (n1 > 0) chk($sformatf("rnd%0d head1", c), bus1.io_data, exp_q1[0][31:0]);
            if (n1 > 0) chk($sformatf("rnd%0d head1 addr", c), 32'(bus1.io_addr), 32'(exp_q1[0][39:32]));

            if (deq0) void'(exp_q.pop_front());
            if (acc0) exp_q.push_back({a[7:0], d});
            if (deq1) void'(exp_q1.pop_front());
            if (acc1) exp_q1.push_back({a[7:0], d});
            else if (enq && drops1 < 65535) drops1++;
            if (we && !mmio) begin
                mram[idx]   = d;
                mknown[idx] = 1'b1;
            end
            hold = expStall0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
